// File: rtl/agc_pkg.sv
// rtl/agc_pkg.sv - shared state encoding, default constants and shift clamp helper for the AGC
package agc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_EVAL   = 2'd2,
        ST_SETTLE = 2'd3
    } agc_state_t;

    localparam int DEF_WIN_LOG2  = 8;
    localparam int DEF_SETTLE    = 4;
    localparam int DEF_MAX_SHIFT = 15;

    function automatic logic [7:0] clamp_shift(input logic [7:0] amp, input logic [7:0] max_amp);
        return (amp > max_amp) ? max_amp : amp;
    endfunction

endpackage

// File: rtl/agc_sat_shift.sv
// rtl/agc_sat_shift.sv - combinational signed left shift with saturation to N bits
module agc_sat_shift
    import agc_pkg::*;
#(
    parameter int N         = 16,
    parameter int MAX_SHIFT = DEF_MAX_SHIFT
) (
    input  logic [N-1:0] data,
    input  logic [7:0]   shift,
    output logic [N-1:0] result,
    output logic         sat
);

    localparam int W = N + MAX_SHIFT;

    logic [W-1:0] wide;
    logic [7:0]   amt;
    logic [MAX_SHIFT:0] upper;

    // The wide result always fits, so its sign bit is the true sign of the shifted sample.
    always_comb begin
        amt    = clamp_shift(shift, 8'(MAX_SHIFT));
        wide   = {{MAX_SHIFT{data[N-1]}}, data} << amt;
        upper  = wide[W-1:N-1];
        sat    = !((&upper) || !(|upper));
        result = wide[N-1:0];
        if (sat) begin
            result = wide[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end

endmodule

// File: rtl/agc_controller.sv
// rtl/agc_controller.sv - peak-tracking automatic gain control with one-cycle saturating datapath
module agc_controller
    import agc_pkg::*;
#(
    parameter int N         = 16,
    parameter int WIN_LOG2  = DEF_WIN_LOG2,
    parameter int SETTLE    = DEF_SETTLE,
    parameter int MAX_SHIFT = DEF_MAX_SHIFT
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         en_i,
    input  logic         manual_i,
    input  logic [7:0]   manual_amp_i,
    input  logic [N-2:0] target_i,
    input  logic [N-2:0] hyst_i,
    input  logic         valid_i,
    input  logic [N-1:0] data_i,
    output logic [7:0]   amplify_o,
    output logic [N-1:0] data_o,
    output logic         valid_o,
    output logic         sat_o,
    output logic         update_o
);

    localparam int GW = N - 1 + MAX_SHIFT;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [7:0] AMP_MAX = 8'(MAX_SHIFT);

    agc_state_t    state;
    logic [N-2:0]  peak;
    logic [WIN_LOG2-1:0] count;
    logic [SW-1:0] settle_cnt;

    logic [N-2:0]  mag;
    logic [N-2:0]  neg_low;
    logic [N-2:0]  peak_next;
    logic [GW-1:0] gain;
    logic [N-1:0]  hi_thr;
    logic [N-2:0]  lo_thr;
    logic          go_down;
    logic          go_up;
    logic [N-1:0]  shift_res;
    logic          shift_sat;

    agc_sat_shift #(
        .N         (N),
        .MAX_SHIFT (MAX_SHIFT)
    ) u_shift (
        .data   (data_i),
        .shift  (amplify_o),
        .result (shift_res),
        .sat    (shift_sat)
    );

    // Magnitude is N-1 bits wide; the most negative input saturates to the largest positive value.
    always_comb begin
        neg_low = ~data_i[N-2:0] + 1'b1;
        mag     = data_i[N-2:0];
        if (data_i[N-1]) begin
            mag = (data_i[N-2:0] == '0) ? '1 : neg_low;
        end
        peak_next = (mag > peak) ? mag : peak;
        gain      = GW'(peak) << amplify_o;
        hi_thr    = {1'b0, target_i} + {1'b0, hyst_i};
        lo_thr    = (target_i > hyst_i) ? (target_i - hyst_i) : '0;
        go_down   = (gain > GW'(hi_thr)) && (amplify_o != 8'd0);
        go_up     = (gain < GW'(lo_thr)) && (amplify_o < AMP_MAX);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            sat_o   <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                data_o <= shift_res;
                sat_o  <= shift_sat;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            amplify_o  <= 8'd0;
            update_o   <= 1'b0;
            peak       <= '0;
            count      <= '0;
            settle_cnt <= '0;
        end else begin
            update_o <= 1'b0;
            if (manual_i) begin
                amplify_o <= clamp_shift(manual_amp_i, AMP_MAX);
            end
            // Leaving automatic mode wins over anything the window would have done this cycle.
            if (manual_i || !en_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_ACCUM;
                        peak  <= '0;
                        count <= '0;
                    end
                    ST_ACCUM: begin
                        if (valid_i) begin
                            peak  <= peak_next;
                            count <= count + 1'b1;
                            if (count == '1) begin
                                state <= ST_EVAL;
                            end
                        end
                    end
                    ST_EVAL: begin
                        peak  <= '0;
                        count <= '0;
                        if (go_down || go_up) begin
                            amplify_o  <= go_down ? amplify_o - 8'd1 : amplify_o + 8'd1;
                            update_o   <= 1'b1;
                            settle_cnt <= '0;
                            state      <= (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                    ST_SETTLE: begin
                        if (valid_i) begin
                            if (settle_cnt == SW'(SETTLE - 1)) begin
                                state <= ST_ACCUM;
                                peak  <= '0;
                                count <= '0;
                            end else begin
                                settle_cnt <= settle_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
